draw_scheduler: RTL

- Sequences the screen/tile blitter. Collects draw requests from game-logic requesters (players, bombs, explosions, …) and from the screen-state logic.
- Arbitrates between them: screen draws have fixed priority, tiles are served round-robin.
- Converts grid coordinates to pixel coordinates and issues exactly one blit at a time using a go/finished handshake.
- Sits between game FSMs and the blitter that feeds the VGA adapter.

---
 rtl/draw_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/draw_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the draw scheduler:
//   - blitter memory-select encodings (title/game/end screens, tile set)
//   - grid-to-pixel shift and default grid dimensions (320x240, 16x16 tiles)
//   - scheduler state encoding and sticky error bit positions
//   - helpers converting grid coordinates to pixel origins
// -----------------------------------------------------------------------------
package draw_pkg;

  localparam logic [1:0] MEM_TITLE = 2'b00;
  localparam logic [1:0] MEM_GAME  = 2'b01;
  localparam logic [1:0] MEM_END   = 2'b10;
  localparam logic [1:0] MEM_TILE  = 2'b11;

  localparam int TILE_SHIFT    = 4;
  localparam int GRID_COLS_DEF = 20;
  localparam int GRID_ROWS_DEF = 15;

  // Sticky error flag positions
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_ILLEGAL = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LAUNCH    = 2'b01,
    ST_WAIT_DONE = 2'b10,
    ST_COOLDOWN  = 2'b11
  } state_t;

  // Grid column -> pixel X origin (col * 16)
  function automatic logic [8:0] col_to_px(input logic [4:0] col);
    return 9'(col) << TILE_SHIFT;
  endfunction

  // Grid row -> pixel Y origin (row * 16)
  function automatic logic [7:0] row_to_px(input logic [3:0] row);
    return 8'(row) << TILE_SHIFT;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Searches i_req starting at
// (i_ptr+1) mod N upward with wrap and returns the first asserted request.
// Ports:
//   i_req   [N]  request vector
//   i_ptr   [IW] index of the most recently granted requester
//   o_grant [N]  one-hot grant (all zero when nothing requests)
//   o_idx   [IW] index of the granted requester
//   o_valid      some request was selected
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Wrap-around priority search; k=N revisits ptr itself last
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[j]) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Collects full-screen and tile draw requests, arbitrates (screen first, tiles
// round-robin), converts grid coordinates to pixel origins and issues one
// blit at a time with a go/finished handshake. All outputs are registered.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req/req_tile/req_col/req_row   per-requester tile request and payload
//   grant               one-hot 1-cycle pulse: tile request consumed
//   screen_req/screen_sel/screen_ack  full-screen request, select, ack pulse
//   blit_go/blit_x/blit_y/blit_mem_sel/blit_tile  command to the blitter
//   blit_finished       blitter done pulse (only honoured in WAIT_DONE)
//   busy                state is not IDLE
//   err                 sticky: bit0 timeout, bit1 dropped illegal request
// -----------------------------------------------------------------------------
import draw_pkg::*;

module draw_scheduler #(
  parameter int N_REQ     = 4,
  parameter int GRID_COLS = GRID_COLS_DEF,
  parameter int GRID_ROWS = GRID_ROWS_DEF,
  parameter int COOLDOWN  = 2,        // must be >= 1
  parameter int TIMEOUT   = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_tile,
  input  logic [5*N_REQ-1:0] req_col,
  input  logic [4*N_REQ-1:0] req_row,
  output logic [N_REQ-1:0]   grant,
  input  logic               screen_req,
  input  logic [1:0]         screen_sel,
  output logic               screen_ack,
  output logic               blit_go,
  output logic [8:0]         blit_x,
  output logic [7:0]         blit_y,
  output logic [1:0]         blit_mem_sel,
  output logic [3:0]         blit_tile,
  input  logic               blit_finished,
  output logic               busy,
  output logic [1:0]         err
);

  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > COOLDOWN) ? TIMEOUT : COOLDOWN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_go, w_go_nxt;
  logic [8:0]         r_x, w_x_nxt;
  logic [7:0]         r_y, w_y_nxt;
  logic [1:0]         r_mem, w_mem_nxt;
  logic [3:0]         r_tile, w_tile_nxt;
  logic               r_busy;
  logic [1:0]         r_err, w_err_nxt;

  logic [N_REQ-1:0]   w_arb_grant;
  logic [IW-1:0]      w_arb_idx;
  logic               w_arb_valid;
  logic [4:0]         w_col;
  logic [3:0]         w_row;
  logic [3:0]         w_tile;
  logic               w_tile_illegal;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Payload of the requester the arbiter picked
  always_comb begin
    w_col          = req_col[int'(w_arb_idx)*5 +: 5];
    w_row          = req_row[int'(w_arb_idx)*4 +: 4];
    w_tile         = req_tile[int'(w_arb_idx)*4 +: 4];
    w_tile_illegal = (int'(w_col) >= GRID_COLS) || (int'(w_row) >= GRID_ROWS);
  end

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = '0;
    w_ack_nxt   = 1'b0;
    w_go_nxt    = 1'b0;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_mem_nxt   = r_mem;
    w_tile_nxt  = r_tile;
    w_err_nxt   = r_err;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (screen_req) begin
          w_ack_nxt = 1'b1;
          // 2'b11 on screen_sel would select the tile set: reject it
          if (screen_sel == MEM_TILE) begin
            w_err_nxt[ERR_ILLEGAL] = 1'b1;
            w_state_nxt            = ST_COOLDOWN;
          end else begin
            w_go_nxt    = 1'b1;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_mem_nxt   = screen_sel;
            w_tile_nxt  = '0;
            w_state_nxt = ST_LAUNCH;
          end
        end else if (w_arb_valid) begin
          w_grant_nxt = w_arb_grant;
          w_ptr_nxt   = w_arb_idx;
          if (w_tile_illegal) begin
            w_err_nxt[ERR_ILLEGAL] = 1'b1;
            w_state_nxt            = ST_COOLDOWN;
          end else begin
            w_go_nxt    = 1'b1;
            w_x_nxt     = col_to_px(w_col);
            w_y_nxt     = row_to_px(w_row);
            w_mem_nxt   = MEM_TILE;
            w_tile_nxt  = w_tile;
            w_state_nxt = ST_LAUNCH;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        // Watchdog already runs here so the timeout lands TIMEOUT cycles after go
        w_cnt_nxt   = r_cnt + 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (blit_finished) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_COOLDOWN;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_cnt_nxt              = '0;
          w_state_nxt            = ST_COOLDOWN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (r_cnt == CNT_W'(COOLDOWN - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= IW'(N_REQ - 1);
      r_grant <= '0;
      r_ack   <= 1'b0;
      r_go    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_mem   <= '0;
      r_tile  <= '0;
      r_busy  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_go    <= w_go_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_mem   <= w_mem_nxt;
      r_tile  <= w_tile_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_err   <= w_err_nxt;
    end
  end

  assign grant        = r_grant;
  assign screen_ack   = r_ack;
  assign blit_go      = r_go;
  assign blit_x       = r_x;
  assign blit_y       = r_y;
  assign blit_mem_sel = r_mem;
  assign blit_tile    = r_tile;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule
